// File: rtl/modalu_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : modalu_gen                                                   |
// | Description : Sequential N-bit modular ALU computing Z = X op Y mod M for  |
// |               a runtime modulus. Add and subtract finish in one cycle;     |
// |               multiply and square use an MSB-first interleaved shift-add   |
// |               reduction, one multiplier bit per cycle.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module modalu_gen #(
    parameter int N = 448
) (
    input  logic         clk,
    input  logic         rst,        // synchronous, active-low
    input  logic [1:0]   op,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic [N-1:0] M,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         req_busy,
    output logic [N-1:0] Z,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_SQR = 2'b11;

    logic [1:0]       r_state;
    logic             r_req_ready;
    logic [1:0]       r_op;
    logic [N-1:0]     r_x;
    logic [N-1:0]     r_y;
    logic [N-1:0]     r_m;
    logic [N-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_z;

    logic             w_accept;
    logic             w_last;
    logic [N:0]       w_m_ext;
    logic [N:0]       w_add_sum;
    logic [N:0]       w_add_res;
    logic [N:0]       w_sub_res;
    logic [N:0]       w_dbl;
    logic [N:0]       w_dbl_red;
    logic [N:0]       w_plus_y;
    logic [N:0]       w_plus_y_red;
    logic [N:0]       w_acc_next;
    logic [N-1:0]     w_result;

    assign w_accept = (r_state == c_IDLE) && r_req_ready && req_valid;
    assign w_m_ext  = {1'b0, r_m};

    // Single-cycle add/sub: one conditional correction brings the result into [0, M).
    always_comb begin
        w_add_sum = {1'b0, r_x} + {1'b0, r_y};
        w_add_res = (w_add_sum >= w_m_ext) ? (w_add_sum - w_m_ext) : w_add_sum;
        if ({1'b0, r_x} >= {1'b0, r_y}) begin
            w_sub_res = {1'b0, r_x} - {1'b0, r_y};
        end else begin
            w_sub_res = {1'b0, r_x} - {1'b0, r_y} + w_m_ext;
        end
    end

    // One shift-add step: acc' = 2*acc (+Y when the current multiplier bit is set), each
    // stage reduced once so everything stays below 2M and fits in N+1 bits.
    always_comb begin
        w_dbl        = {r_acc, 1'b0};
        w_dbl_red    = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
        w_plus_y     = w_dbl_red + {1'b0, r_y};
        w_plus_y_red = (w_plus_y >= w_m_ext) ? (w_plus_y - w_m_ext) : w_plus_y;
        w_acc_next   = r_x[r_cnt] ? w_plus_y_red : w_dbl_red;
    end

    // Select the value written to Z on the final RUN cycle of each operation.
    always_comb begin
        w_last   = 1'b0;
        w_result = '0;
        case (r_op)
            c_OP_ADD: begin
                w_last   = 1'b1;
                w_result = w_add_res[N-1:0];
            end
            c_OP_SUB: begin
                w_last   = 1'b1;
                w_result = w_sub_res[N-1:0];
            end
            c_OP_MUL, c_OP_SQR: begin
                w_last   = (r_cnt == '0);
                w_result = w_acc_next[N-1:0];
            end
            default: begin
                w_last   = 1'b1;
                w_result = '0;
            end
        endcase
    end

    // Control FSM and handshake; req_ready is registered so it stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state     <= c_RUN;
                        r_req_ready <= 1'b0;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (res_ready) begin
                        r_state     <= c_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture on accept; square reuses X as the multiplicand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op <= c_OP_ADD;
            r_x  <= '0;
            r_y  <= '0;
            r_m  <= '0;
        end else if (w_accept) begin
            r_op <= op;
            r_x  <= X;
            r_y  <= (op == c_OP_SQR) ? X : Y;
            r_m  <= M;
        end
    end

    // Accumulator and bit counter: cleared on accept, one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_cnt <= CNT_W'(N - 1);
        end else if (r_state == c_RUN) begin
            r_acc <= w_acc_next[N-1:0];
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result register: written only on the RUN->DONE transition, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_z <= '0;
        end else if ((r_state == c_RUN) && w_last) begin
            r_z <= w_result;
        end
    end

    assign req_ready = r_req_ready;
    assign req_busy  = (r_state == c_RUN);
    assign res_valid = (r_state == c_DONE);
    assign Z         = r_z;

endmodule
`default_nettype wire

// File: tb/tb_modalu_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_modalu_gen                                                |
// | Description : Self-checking bench for modalu_gen (N=8) with an arithmetic  |
// |               reference model and directed hand-computed vectors.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_modalu_gen;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] X = '0;
    logic [N-1:0] Y = '0;
    logic [N-1:0] M = '0;
    logic         req_valid = 1'b0;
    logic         res_ready = 1'b1;
    logic         req_ready;
    logic         req_busy;
    logic [N-1:0] Z;
    logic         res_valid;

    int total = 0;
    int bad   = 0;

    modalu_gen #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .X         (X),
        .Y         (Y),
        .M         (M),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_busy  (req_busy),
        .Z         (Z),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer modular math.
    function automatic logic [N-1:0] ref_result(input logic [1:0] o, input logic [N-1:0] a,
                                                input logic [N-1:0] b, input logic [N-1:0] m);
        int ia = int'(a);
        int ib = int'(b);
        int im = int'(m);
        int r;
        case (o)
            2'b00:   r = (ia + ib) % im;
            2'b01:   r = (ia - ib + im) % im;
            2'b10:   r = (ia * ib) % im;
            default: r = (ia * ia) % im;
        endcase
        return N'(r);
    endfunction

    function automatic bit pre_ok(input logic [1:0] o, input logic [N-1:0] a,
                                  input logic [N-1:0] b, input logic [N-1:0] m);
        return (m > 2) && (a < m) && ((o == 2'b11) || (b < m));
    endfunction

    // Transaction-level model of the handshake and results.
    logic         m_live   = 1'b0;
    logic         m_ready  = 1'b0;
    logic         m_busy   = 1'b0;
    logic         m_valid  = 1'b0;
    logic         m_zknown = 1'b0;
    logic         m_pknown = 1'b0;
    logic [N-1:0] m_z      = '0;
    logic [N-1:0] m_pend   = '0;
    int           m_left   = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_live   <= 1'b1;
            m_ready  <= 1'b0;
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_z      <= '0;
            m_zknown <= 1'b1;
        end else if (m_ready && req_valid) begin
            m_ready  <= 1'b0;
            m_busy   <= 1'b1;
            m_left   <= op[1] ? N : 1;
            m_pend   <= (M == 0) ? '0 : ref_result(op, X, Y, M);
            m_pknown <= (M != 0) && pre_ok(op, X, Y, M);
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_valid  <= 1'b1;
                m_z      <= m_pend;
                m_zknown <= m_pknown;
            end
            m_left <= m_left - 1;
        end else if (m_valid) begin
            if (res_ready) begin
                m_valid <= 1'b0;
                m_ready <= 1'b1;
            end
        end else begin
            m_ready <= 1'b1;
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_live) begin
            chk("mon_req_ready", req_ready, m_ready);
            chk("mon_req_busy", req_busy, m_busy);
            chk("mon_res_valid", res_valid, m_valid);
            if (m_zknown) chk("mon_Z", Z, m_z);
        end
    end

    // Issue one request; check latency and optionally a literal result.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input int exp_lat, input bit use_lit,
                          input logic [N-1:0] lit, input string name);
        int waitc = 0;
        int cycles = 0;
        op = o; X = a; Y = b; M = m;
        req_valid = 1'b1;
        while (!req_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!req_ready) begin
            chk({name, "_accept_timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        op = ~o; X = ~a; Y = ~b; M = ~m;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!res_valid && cycles < 600);
        chk({name, "_latency"}, cycles, exp_lat);
        if (use_lit) chk({name, "_Z"}, Z, lit);
        if (res_ready) begin
            @(posedge clk); #1;
            chk({name, "_back_idle"}, req_ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded bound");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] held;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_req_busy", req_busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_Z", Z, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", req_ready, 1);

        run_op(2'b00, 8'd200, 8'd100, 8'd251, 1, 1'b1, 8'd49,  "add");
        run_op(2'b01, 8'd100, 8'd200, 8'd251, 1, 1'b1, 8'd151, "sub_wrap");
        run_op(2'b01, 8'd77,  8'd77,  8'd251, 1, 1'b1, 8'd0,   "sub_zero");
        run_op(2'b10, 8'd200, 8'd100, 8'd251, N, 1'b1, 8'd171, "mul");
        run_op(2'b11, 8'd250, 8'd123, 8'd251, N, 1'b1, 8'd1,   "sq");
        run_op(2'b00, 8'd250, 8'd250, 8'd251, 1, 1'b1, 8'd249, "add_max");
        run_op(2'b01, 8'd0,   8'd250, 8'd251, 1, 1'b1, 8'd1,   "sub_min");
        run_op(2'b10, 8'd2,   8'd2,   8'd3,   N, 1'b1, 8'd1,   "mul_m3");
        run_op(2'b10, 8'd255, 8'd255, 8'd251, N, 1'b0, 8'd0,   "mul_badpre");
        run_op(2'b00, 8'd1,   8'd1,   8'd2,   1, 1'b0, 8'd0,   "add_badm");
        run_op(2'b10, 8'd0,   8'd137, 8'd251, N, 1'b1, 8'd0,   "mul_zero");

        // Backpressure in DONE.
        res_ready = 1'b0;
        run_op(2'b10, 8'd17, 8'd33, 8'd251, N, 1'b1, 8'd59, "bp_mul");
        held = Z;
        for (int i = 0; i < 20; i++) begin
            chk("bp_res_valid", res_valid, 1);
            chk("bp_Z_stable", Z, held);
            chk("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_ready", req_ready, 1);

        // req_valid held high: back-to-back adds on every IDLE visit.
        op = 2'b00; X = 8'd1; Y = 8'd2; M = 8'd251;
        req_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_Z", Z, 3);

        // Reset in the middle of a multiply.
        op = 2'b10; X = 8'd200; Y = 8'd100; M = 8'd251;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_before", req_busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", req_busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_Z", Z, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 8'd200, 8'd100, 8'd251, 1, 1'b1, 8'd49, "post_rst_add");

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
